// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: NCH valid/ready producers in, one valid/ready consumer out.
interface arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/arb_mux.sv
// Registered N-channel arbitrating mux: fixed-priority or round-robin grant into a
// one-deep output register that can drain and refill in the same cycle.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  arb_mux_if.slave   bus
);
  localparam int SELW = $clog2(NCH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  data_reg, data_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [SELW-1:0]   ptr_reg, ptr_next;

  logic [WIDTH-1:0]  chan_data [NCH];
  logic [SELW-1:0]   fixed_grant, rr_grant, grant;
  logic              any_valid, can_load, xfer;
  int                rr_idx;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan_data[gi]    = bus.in_data[gi*WIDTH +: WIDTH];
      assign bus.in_ready[gi] = xfer && (grant == SELW'(gi));
    end
  endgenerate

  // Descending scans so the last hit, i.e. the first in search order, wins.
  always_comb begin
    fixed_grant = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) fixed_grant = SELW'(i);
    end
  end

  always_comb begin
    rr_grant = '0;
    rr_idx   = 0;
    for (int i = NCH; i >= 1; i--) begin
      rr_idx = int'(ptr_reg) + i;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (bus.in_valid[rr_idx]) rr_grant = SELW'(rr_idx);
    end
  end

  assign grant     = mode ? rr_grant : fixed_grant;
  assign any_valid = |bus.in_valid;
  assign can_load  = (state_reg == EMPTY) || bus.out_ready;
  // rst_n gates in_ready so no producer sees an accept while reset is held.
  assign xfer      = rst_n && can_load && any_valid;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    if (xfer) begin
      state_next = FULL;
      data_next  = chan_data[grant];
      sel_next   = grant;
      ptr_next   = grant;
    end else if (state_reg == FULL && bus.out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      sel_reg   <= '0;
      ptr_reg   <= SELW'(NCH - 1);
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = data_reg;
  assign bus.out_sel   = sel_reg;
endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed test-plan sequences plus randomized traffic
// checked against a queue-based arbitration model.
module tb_arb_mux;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;

  arb_mux_if #(.WIDTH(W), .NCH(N)) bus ();

  arb_mux #(.WIDTH(W), .NCH(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] chan_word [N];

  // Model state: what the output register must hold and where round-robin resumes.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = N - 1;
  endtask

  // Search order is an explicit list of channel numbers; the grant is the first requester in it.
  function automatic int model_grant(input logic md, input logic [N-1:0] v);
    int order[$];
    order = {};
    for (int k = 0; k < N; k++) begin
      if (md) order.push_back((m_ptr + 1 + k) % N);
      else    order.push_back(k);
    end
    foreach (order[j]) begin
      if (v[order[j]]) return order[j];
    end
    return -1;
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    chk({tag, ".out_data"},  64'(bus.out_data),  64'(m_data));
    chk({tag, ".out_sel"},   64'(bus.out_sel),   64'(m_sel));
  endtask

  task automatic step(input logic md, input logic [N-1:0] v, input logic rdy);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    mode          = md;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = chan_word[i];
    #1;
    g = model_grant(md, v);
    exp_rdy = '0;
    if (rst_n && (!m_valid || rdy) && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk_outputs("pre");
    @(posedge clk);
    if (exp_rdy != '0) begin
      m_valid = 1'b1;
      m_data  = chan_word[g];
      m_sel   = g;
      m_ptr   = g;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk_outputs("post");
  endtask

  // Reset asserted between edges must clear outputs without any clock edge.
  task automatic rst_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.out_data",  64'(bus.out_data),  64'd0);
    chk("rst.out_sel",   64'(bus.out_sel),   64'd0);
    chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
    bus.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_word(input string name, input logic [W-1:0] d, input int s);
    chk({name, ".data"}, 64'(bus.out_data), 64'(d));
    chk({name, ".sel"},  64'(bus.out_sel),  64'(s));
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) chan_word[i] = W'(i + 1);
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = chan_word[i];

    // Held in reset with every channel requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rst.in_ready",  64'(bus.in_ready),  64'd0);
    chk("hold_rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("hold_rst.out_data",  64'(bus.out_data),  64'd0);
    chk("hold_rst.out_sel",   64'(bus.out_sel),   64'd0);
    bus.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: channel 0 wins every cycle.
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'b1111, 1'b1);
      expect_word("fixed", 32'h1, 0);
      chk("fixed.in_ready", 64'(bus.in_ready), 64'b0001);
    end

    // Round-robin from a fresh reset starts at channel 0.
    rst_pulse();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b1111, 1'b1);
      expect_word("rr", W'((c % N) + 1), c % N);
    end

    // Backpressure: held word frozen, no accepts.
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b1111, 1'b0);
      expect_word("stall", 32'h1, 0);
      chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
    end
    step(1'b1, 4'b1111, 1'b1);
    expect_word("release", 32'h2, 1);
    chk("release.out_valid", 64'(bus.out_valid), 64'd1);

    // Sparse requesters 1 and 3 alternate, wrapping past the top.
    step(1'b1, 4'b1010, 1'b1); expect_word("sparse0", 32'h4, 3);
    step(1'b1, 4'b1010, 1'b1); expect_word("sparse1", 32'h2, 1);
    step(1'b1, 4'b1010, 1'b1); expect_word("sparse2", 32'h4, 3);
    step(1'b1, 4'b1010, 1'b1); expect_word("sparse3", 32'h2, 1);

    // Mode switch after a channel-2 grant goes back to channel 0.
    step(1'b1, 4'b1111, 1'b1); expect_word("mode_rr", 32'h3, 2);
    step(1'b0, 4'b1111, 1'b1); expect_word("mode_fix", 32'h1, 0);
    chk("mode_fix.out_valid", 64'(bus.out_valid), 64'd1);

    // Reset with a word held, then round-robin restarts at channel 0.
    rst_pulse();
    step(1'b1, 4'b1111, 1'b1); expect_word("recover", 32'h1, 0);

    // Drain without refill.
    step(1'b1, 4'b0000, 1'b1);
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain.out_data",  64'(bus.out_data),  64'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) chan_word[i] = $urandom;
      if ($urandom_range(99) == 0) rst_pulse();
      else step(1'($urandom_range(1)), N'($urandom), ($urandom_range(9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
